surf_link_autotrain: RTL and testbench

//  Automatic multi-lane receive aligner for SURF COUT/DOUT links. Replaces manual software

---
 rtl/surf_link_autotrain_if.sv | 32 +++
 rtl/surf_link_autotrain.sv | 207 ++++++++++++++++++++
 tb/tb_surf_link_autotrain.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/surf_link_autotrain_if.sv
// surf_link_autotrain_if: start/mask control, per-lane deserialized data and training results
// of the SURF link auto-trainer, bundled so the trainer and its user share one definition.
interface surf_link_autotrain_if #(
    parameter int NLANES  = 4,
    parameter int DWIDTH  = 32,
    parameter int TAPBITS = 5
);
    logic                       start_i;
    logic [NLANES-1:0]          lane_mask_i;
    logic [NLANES*DWIDTH-1:0]   lane_data_i;
    logic [NLANES-1:0]          lane_valid_i;
    logic                       iserdes_rst_o;
    logic [TAPBITS-1:0]         idelay_value_o;
    logic [NLANES-1:0]          idelay_load_o;
    logic [NLANES-1:0]          bitslip_o;
    logic                       busy_o;
    logic                       done_o;
    logic [NLANES-1:0]          lane_locked_o;
    logic [NLANES-1:0]          lane_fail_o;
    logic [NLANES*TAPBITS-1:0]  lane_tap_o;

    modport slave (
        input  start_i, lane_mask_i, lane_data_i, lane_valid_i,
        output iserdes_rst_o, idelay_value_o, idelay_load_o, bitslip_o,
               busy_o, done_o, lane_locked_o, lane_fail_o, lane_tap_o
    );
    modport master (
        output start_i, lane_mask_i, lane_data_i, lane_valid_i,
        input  iserdes_rst_o, idelay_value_o, idelay_load_o, bitslip_o,
               busy_o, done_o, lane_locked_o, lane_fail_o, lane_tap_o
    );
endinterface

// File: rtl/surf_link_autotrain.sv
// surf_link_autotrain: trains enabled lanes one at a time -- scans every IDELAY tap against the
// training word, centres on the widest clean eye, then bitslips until the word lines up.
module surf_link_autotrain #(
    parameter int          NLANES         = 4,
    parameter int          DWIDTH         = 32,
    parameter int          TAPBITS        = 5,
    parameter logic [31:0] TRAIN_SEQUENCE = 32'hA55A6996,
    parameter int          SETTLE_CYCLES  = 16,
    parameter int          CHECK_WORDS    = 64,
    parameter int          MIN_EYE        = 4,
    parameter int          RST_CYCLES     = 8
) (
    input  logic                 sysclk_i,
    input  logic                 sysclk_rst_i,
    surf_link_autotrain_if.slave link
);
    localparam int LW = NLANES > 1 ? $clog2(NLANES) : 1;
    localparam int SW = $clog2(DWIDTH) + 1;
    localparam logic [DWIDTH-1:0]   TRAIN = TRAIN_SEQUENCE[DWIDTH-1:0];
    localparam logic [2*DWIDTH-1:0] TT    = {TRAIN, TRAIN};

    typedef enum logic [3:0] {
        S_IDLE, S_LRST, S_LOAD, S_SETTLE, S_CHECK, S_PICK, S_CLOAD,
        S_CSETTLE, S_ALIGN, S_SLIP, S_SWAIT, S_NEXT
    } state_t;

    state_t                    r_state;
    logic [NLANES-1:0]         r_pend;
    logic [LW-1:0]             r_lane;
    logic [15:0]               r_cnt;
    logic [SW-1:0]             r_slips;
    logic [TAPBITS-1:0]        r_tap, r_run_start, r_best_start;
    logic [TAPBITS:0]          r_run_len, r_best_len;
    logic                      r_lk, r_fl;
    logic                      r_iserdes_rst, r_busy, r_done;
    logic [TAPBITS-1:0]        r_idelay_value;
    logic [NLANES-1:0]         r_idelay_load, r_bitslip, r_locked, r_fail;
    logic [NLANES*TAPBITS-1:0] r_tap_out;

    logic [DWIDTH-1:0]  w_word;
    logic               w_valid, w_rot_ok;
    logic [LW-1:0]      w_nxt;
    logic [NLANES-1:0]  w_lane_oh;
    logic [TAPBITS:0]   w_ext_len, w_cand_len;
    logic [TAPBITS-1:0] w_ext_start, w_cand_start, w_centre;

    assign w_word       = link.lane_data_i[int'(r_lane)*DWIDTH +: DWIDTH];
    assign w_valid      = link.lane_valid_i[r_lane];
    assign w_lane_oh    = NLANES'(1) << r_lane;
    assign w_ext_len    = r_run_len + 1'b1;
    assign w_ext_start  = r_run_len == '0 ? r_tap : r_run_start;
    assign w_cand_len   = w_rot_ok ? w_ext_len : r_run_len;
    assign w_cand_start = w_rot_ok ? w_ext_start : r_run_start;
    assign w_centre     = r_best_start + TAPBITS'((r_best_len - 1'b1) >> 1);

    // Tap quality does not depend on word alignment: any rotation of the pattern counts.
    always_comb begin
        w_rot_ok = 1'b0;
        for (int r = 0; r < DWIDTH; r++) w_rot_ok = w_rot_ok | (TT[r +: DWIDTH] == w_word);
    end

    always_comb begin
        w_nxt = '0;
        for (int i = NLANES - 1; i >= 0; i--) if (r_pend[i]) w_nxt = LW'(i);
    end

    always_ff @(posedge sysclk_i or posedge sysclk_rst_i) begin
        if (sysclk_rst_i) begin
            r_state        <= S_IDLE;
            r_pend         <= '0;
            r_lane         <= '0;
            r_cnt          <= '0;
            r_slips        <= '0;
            r_tap          <= '0;
            r_run_start    <= '0;
            r_run_len      <= '0;
            r_best_start   <= '0;
            r_best_len     <= '0;
            r_lk           <= 1'b0;
            r_fl           <= 1'b0;
            r_iserdes_rst  <= 1'b0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
            r_idelay_value <= '0;
            r_idelay_load  <= '0;
            r_bitslip      <= '0;
            r_locked       <= '0;
            r_fail         <= '0;
            r_tap_out      <= '0;
        end else begin
            r_idelay_load <= '0;
            r_bitslip     <= '0;
            r_done        <= 1'b0;
            case (r_state)
                S_IDLE: if (link.start_i) begin
                    r_pend    <= link.lane_mask_i;
                    r_locked  <= '0;
                    r_fail    <= '0;
                    r_tap_out <= '0;
                    r_lk      <= 1'b0;
                    r_fl      <= 1'b0;
                    r_busy    <= 1'b1;
                    r_state   <= S_NEXT;
                end
                S_LRST: if (r_cnt == 16'(RST_CYCLES - 1)) begin
                    r_iserdes_rst  <= 1'b0;
                    r_tap          <= '0;
                    r_idelay_value <= '0;
                    r_idelay_load  <= w_lane_oh;
                    r_state        <= S_LOAD;
                end else r_cnt <= r_cnt + 1'b1;
                S_LOAD: begin
                    r_cnt   <= '0;
                    r_state <= S_SETTLE;
                end
                S_SETTLE: if (r_cnt == 16'(SETTLE_CYCLES - 1)) begin
                    r_cnt   <= '0;
                    r_state <= S_CHECK;
                end else r_cnt <= r_cnt + 1'b1;
                S_CHECK: if (w_valid) begin
                    if (w_rot_ok && r_cnt != 16'(CHECK_WORDS - 1)) r_cnt <= r_cnt + 1'b1;
                    else begin
                        r_run_len   <= w_rot_ok ? w_ext_len : '0;
                        r_run_start <= w_ext_start;
                        // A run closes on a bad tap or at the last tap; ties keep the earlier eye.
                        if ((!w_rot_ok || &r_tap) && w_cand_len > r_best_len) begin
                            r_best_len   <= w_cand_len;
                            r_best_start <= w_cand_start;
                        end
                        if (&r_tap) r_state <= S_PICK;
                        else begin
                            r_tap          <= r_tap + 1'b1;
                            r_idelay_value <= r_tap + 1'b1;
                            r_idelay_load  <= w_lane_oh;
                            r_state        <= S_LOAD;
                        end
                    end
                end
                S_PICK: if (r_best_len < (TAPBITS+1)'(MIN_EYE)) begin
                    r_fl    <= 1'b1;
                    r_state <= S_NEXT;
                end else begin
                    r_tap_out[int'(r_lane)*TAPBITS +: TAPBITS] <= w_centre;
                    r_idelay_value <= w_centre;
                    r_idelay_load  <= w_lane_oh;
                    r_state        <= S_CLOAD;
                end
                S_CLOAD: begin
                    r_cnt   <= '0;
                    r_state <= S_CSETTLE;
                end
                S_CSETTLE, S_SWAIT: if (r_cnt == 16'(SETTLE_CYCLES - 1)) begin
                    if (r_state == S_CSETTLE) r_slips <= '0;
                    r_state <= S_ALIGN;
                end else r_cnt <= r_cnt + 1'b1;
                S_ALIGN: if (w_valid) begin
                    if (w_word == TRAIN) begin
                        r_lk    <= 1'b1;
                        r_state <= S_NEXT;
                    end else if (r_slips == SW'(DWIDTH)) begin
                        r_fl    <= 1'b1;
                        r_state <= S_NEXT;
                    end else begin
                        r_bitslip <= w_lane_oh;
                        r_slips   <= r_slips + 1'b1;
                        r_state   <= S_SLIP;
                    end
                end
                S_SLIP: begin
                    r_cnt   <= '0;
                    r_state <= S_SWAIT;
                end
                S_NEXT: begin
                    r_locked[r_lane] <= r_lk;
                    r_fail[r_lane]   <= r_fl;
                    r_lk             <= 1'b0;
                    r_fl             <= 1'b0;
                    if (|r_pend) begin
                        r_lane         <= w_nxt;
                        r_pend[w_nxt]  <= 1'b0;
                        r_iserdes_rst  <= 1'b1;
                        r_cnt          <= '0;
                        r_run_len      <= '0;
                        r_best_len     <= '0;
                        r_best_start   <= '0;
                        r_state        <= S_LRST;
                    end else begin
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign link.iserdes_rst_o  = r_iserdes_rst;
    assign link.idelay_value_o = r_idelay_value;
    assign link.idelay_load_o  = r_idelay_load;
    assign link.bitslip_o      = r_bitslip;
    assign link.busy_o         = r_busy;
    assign link.done_o         = r_done;
    assign link.lane_locked_o  = r_locked;
    assign link.lane_fail_o    = r_fail;
    assign link.lane_tap_o     = r_tap_out;
endmodule

// File: tb/tb_surf_link_autotrain.sv
// tb_surf_link_autotrain: directed runs of the link auto-trainer against a simple lane model
// whose good taps, initial word rotation and bitslip response are set per test.
module tb_surf_link_autotrain;
    localparam logic [31:0] TR = 32'hA55A6996;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic clr = 1'b0;
    int   total = 0;
    int   bad = 0;

    logic [31:0] gmask [4] = '{default: '0};
    int          r0 [4]    = '{default: 0};
    logic        seff [4]  = '{default: 1'b1};
    logic [4:0]  tap [4]   = '{default: '0};
    int          nload [4] = '{default: 0};
    int          nslip [4] = '{default: 0};
    int          ndone = 0;
    logic        viol = 1'b0;
    logic [31:0] noise = '0;

    surf_link_autotrain_if #(.NLANES(4), .DWIDTH(32), .TAPBITS(5)) lk ();

    surf_link_autotrain dut (.sysclk_i(clk), .sysclk_rst_i(rst), .link(lk));

    always #5 clk = ~clk;

    function automatic logic [31:0] rotl(input logic [31:0] w, input int r);
        logic [63:0] d;
        d = {w, w};
        return d[63-r -: 32];
    endfunction

    // Lane model: good taps return the pattern rotated by r0 plus the slips seen so far.
    always_comb begin
        for (int n = 0; n < 4; n++)
            lk.lane_data_i[n*32 +: 32] = gmask[n][tap[n]]
                ? rotl(TR, seff[n] ? (r0[n] + nslip[n]) % 32 : r0[n]) : noise;
    end

    always @(posedge clk) begin
        noise <= $urandom;
        if ($countones({lk.idelay_load_o, lk.bitslip_o}) > 1) viol <= 1'b1;
        if (clr) begin
            for (int n = 0; n < 4; n++) begin
                nload[n] <= 0;
                nslip[n] <= 0;
            end
            ndone <= 0;
        end else begin
            for (int n = 0; n < 4; n++) begin
                if (lk.idelay_load_o[n]) begin
                    tap[n]   <= lk.idelay_value_o;
                    nload[n] <= nload[n] + 1;
                end
                if (lk.bitslip_o[n]) nslip[n] <= nslip[n] + 1;
            end
            if (lk.done_o) ndone <= ndone + 1;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cfg(input int n, input logic [31:0] gm, input int rot, input logic se);
        gmask[n] = gm;
        r0[n]    = rot;
        seff[n]  = se;
    endtask

    task automatic clear_cfg();
        for (int n = 0; n < 4; n++) cfg(n, 32'h0, 0, 1'b1);
    endtask

    task automatic go(input logic [3:0] m);
        @(negedge clk);
        clr = 1'b1;
        lk.start_i = 1'b1;
        lk.lane_mask_i = m;
        @(negedge clk);
        clr = 1'b0;
        lk.start_i = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int i;
        i = 0;
        while (!lk.done_o && i < 20000) begin
            @(negedge clk);
            i++;
        end
        chk(tag, lk.done_o, 1);
        repeat (3) @(negedge clk);
    endtask

    function automatic logic [63:0] all_outs();
        return {lk.iserdes_rst_o, lk.idelay_value_o, lk.idelay_load_o, lk.bitslip_o, lk.busy_o,
                lk.done_o, lk.lane_locked_o, lk.lane_fail_o, lk.lane_tap_o};
    endfunction

    initial begin
        lk.start_i = 1'b0;
        lk.lane_mask_i = '0;
        lk.lane_valid_i = 4'hF;
        repeat (3) @(negedge clk);
        chk("reset_outputs", all_outs(), 0);
        rst = 1'b0;

        // eye 10..19, pattern rotated by 5; a second start and mask change mid-run are ignored
        clear_cfg();
        cfg(0, 32'h000FFC00, 5, 1'b1);
        go(4'b0001);
        chk("t1_busy", lk.busy_o, 1);
        repeat (5) @(negedge clk);
        lk.start_i = 1'b1;
        lk.lane_mask_i = 4'b1111;
        @(negedge clk);
        lk.start_i = 1'b0;
        wait_done("t1_done");
        chk("t1_busy_after", lk.busy_o, 0);
        chk("t1_tap", lk.lane_tap_o[4:0], 14);
        chk("t1_slips", nslip[0], 27);
        chk("t1_locked", lk.lane_locked_o, 4'b0001);
        chk("t1_fail", lk.lane_fail_o, 4'b0000);
        chk("t1_ndone", ndone, 1);

        // two runs, the short one below MIN_EYE
        clear_cfg();
        cfg(0, 32'h03F0000C, 0, 1'b1);
        go(4'b0001);
        wait_done("t2_done");
        chk("t2_tap", lk.lane_tap_o[4:0], 22);
        chk("t2_locked", lk.lane_locked_o, 4'b0001);
        chk("t2_slips", nslip[0], 0);

        // equal-length runs: earliest wins
        clear_cfg();
        cfg(0, 32'h001F83F0, 0, 1'b1);
        go(4'b0001);
        wait_done("t3_done");
        chk("t3_tap", lk.lane_tap_o[4:0], 6);
        chk("t3_locked", lk.lane_locked_o, 4'b0001);

        // no good tap at all
        clear_cfg();
        go(4'b0001);
        wait_done("t4_done");
        chk("t4_fail", lk.lane_fail_o, 4'b0001);
        chk("t4_locked", lk.lane_locked_o, 4'b0000);
        chk("t4_slips", nslip[0], 0);
        chk("t4_loads", nload[0], 32);
        chk("t4_ndone", ndone, 1);

        // eye fine but slips never bring the word into line
        clear_cfg();
        cfg(0, 32'h000FFC00, 5, 1'b0);
        go(4'b0001);
        wait_done("t5_done");
        chk("t5_slips", nslip[0], 32);
        chk("t5_fail", lk.lane_fail_o, 4'b0001);
        chk("t5_locked", lk.lane_locked_o, 4'b0000);
        chk("t5_tap", lk.lane_tap_o[4:0], 14);

        // sparse mask; the live mask is changed right after start
        clear_cfg();
        cfg(1, 32'h000FFC00, 0, 1'b1);
        cfg(3, 32'h000FFC00, 3, 1'b1);
        go(4'b1010);
        lk.lane_mask_i = 4'b1111;
        wait_done("t6_done");
        chk("t6_locked", lk.lane_locked_o, 4'b1010);
        chk("t6_fail", lk.lane_fail_o, 4'b0000);
        chk("t6_load0", nload[0], 0);
        chk("t6_load2", nload[2], 0);
        chk("t6_load1", nload[1], 33);
        chk("t6_load3", nload[3], 33);
        chk("t6_slip3", nslip[3], 29);
        chk("t6_slip1", nslip[1], 0);
        chk("t6_taps", lk.lane_tap_o, {5'd14, 5'd0, 5'd14, 5'd0});

        // empty mask: done two cycles after start
        @(negedge clk);
        lk.start_i = 1'b1;
        lk.lane_mask_i = 4'b0000;
        @(negedge clk);
        lk.start_i = 1'b0;
        chk("t7_busy1", {lk.busy_o, lk.done_o}, 2'b10);
        @(negedge clk);
        chk("t7_done2", {lk.busy_o, lk.done_o}, 2'b01);
        chk("t7_results", {lk.lane_locked_o, lk.lane_fail_o, lk.lane_tap_o}, 0);
        @(negedge clk);
        chk("t7_done3", lk.done_o, 0);

        // reset while lane 2 is checking a good tap, then a clean restart
        clear_cfg();
        cfg(2, 32'h000FFC00, 0, 1'b1);
        go(4'b0100);
        for (int i = 0; i < 20000 && nload[2] < 12; i++) @(negedge clk);
        chk("t8_reach", nload[2] >= 12, 1);
        repeat (25) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("t8_abort", all_outs(), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        go(4'b0100);
        wait_done("t8_done");
        chk("t8_locked", lk.lane_locked_o, 4'b0100);
        chk("t8_tap", lk.lane_tap_o[14:10], 14);

        chk("onehot_strobes", viol, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
